// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
package freq_meter_pkg;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StGate,
        StDone
    } fm_state_e;

    // Number of flops in the sig_in synchronizer chain.
    localparam int unsigned SyncDepth = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous input into the clk domain and emits a one-cycle pulse
// for every rising edge. The pulse appears 3 clk edges after the input rises.
module sync_edge_detect
    import freq_meter_pkg::*;
(
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic rise
);

    logic [SyncDepth-1:0] sync_q;
    logic                 prev_q;
    logic                 rise_q;

    // Synchronizer chain, previous-value flop and registered edge pulse.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncDepth-2:0], d};
            prev_q <= sync_q[SyncDepth-1];
            rise_q <= sync_q[SyncDepth-1] & ~prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of sig_in over GATE_CYCLES clk cycles and
// presents the result with a valid/ready handshake.
// Optional feature: define FREQ_METER_CONTINUOUS_EN to run back-to-back gates without
// start (the first gate begins one cycle after reset release; start is then ignored).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 27000000,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   sig_in,
    input  logic                   start,
    output logic                   busy,
    output logic                   valid,
    input  logic                   ready,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);

    localparam int unsigned GateWidth = $clog2(GATE_CYCLES);
    localparam logic [GateWidth-1:0] GateLoad = GateWidth'(GATE_CYCLES - 1);

    fm_state_e              state_q;
    logic [GateWidth-1:0]   gate_cnt_q;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   overflow_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   rise;
    logic                   begin_gate;

    sync_edge_detect u_sync_edge_detect (
        .clk    (clk),
        .nreset (nreset),
        .d      (sig_in),
        .rise   (rise)
    );

`ifdef FREQ_METER_CONTINUOUS_EN
    logic unused_start;
    assign unused_start = start;
    assign begin_gate   = 1'b1;
`else
    assign begin_gate   = start;
`endif

    // Saturating edge counter; a pulse arriving at all-ones sets the sticky overflow.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        if (rise) begin
            if (&edge_cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + 1'b1;
            end
        end
    end

    // Measurement FSM with registered busy/valid/count/overflow outputs.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= StIdle;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (begin_gate) begin
                        state_q    <= StGate;
                        busy_q     <= 1'b1;
                        gate_cnt_q <= GateLoad;
                        edge_cnt_q <= '0;
                        ovf_q      <= 1'b0;
                    end
                end
                StGate: begin
                    edge_cnt_q <= edge_cnt_d;
                    ovf_q      <= ovf_d;
                    if (gate_cnt_q == '0) begin
                        // Latch the next-state values so a pulse on this last cycle counts.
                        state_q    <= StDone;
                        busy_q     <= 1'b0;
                        valid_q    <= 1'b1;
                        count_q    <= edge_cnt_d;
                        overflow_q <= ovf_d;
                    end else begin
                        gate_cnt_q <= gate_cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (ready) begin
                        valid_q <= 1'b0;
`ifdef FREQ_METER_CONTINUOUS_EN
                        state_q    <= StGate;
                        busy_q     <= 1'b1;
                        gate_cnt_q <= GateLoad;
                        edge_cnt_q <= '0;
                        ovf_q      <= 1'b0;
`else
                        state_q    <= StIdle;
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter. Two instances share all inputs: a 32-bit counter and
// a 4-bit counter that saturates. Expected counts come from constant tables and from a
// reference model that counts sig_in rises over the recorded sample history.
module tb_freq_meter;

    localparam int unsigned G = 100;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        sig_in = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        busy, valid, overflow;
    logic [31:0] count;
    logic        busy4, valid4, ovf4;
    logic [3:0]  count4;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0: sig_in held, 1: periodic, 2: random
    int period = 10;
    int dens   = 50;
    int phase  = 0;
    bit hist[$];      // sig_in as seen by the DUT at each clk edge (0 while in reset)

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(G), .COUNT_WIDTH(32)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .sig_in   (sig_in),
        .start    (start),
        .busy     (busy),
        .valid    (valid),
        .ready    (ready),
        .count    (count),
        .overflow (overflow)
    );

    freq_meter #(.GATE_CYCLES(G), .COUNT_WIDTH(4)) dut4 (
        .clk      (clk),
        .nreset   (nreset),
        .sig_in   (sig_in),
        .start    (start),
        .busy     (busy4),
        .valid    (valid4),
        .ready    (ready),
        .count    (count4),
        .overflow (ovf4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: record what the DUT sampled, then update the stimulus away from the edge.
    task automatic tick();
        @(posedge clk);
        hist.push_back(nreset ? sig_in : 1'b0);
        #1;
        if (mode == 1) begin
            sig_in = (phase % period) < (period / 2);
            phase++;
        end else if (mode == 2) begin
            sig_in = ($urandom_range(0, 99) < dens);
        end
    endtask

    // Rises whose first high sample lands at edge k are counted at edge k+3; the gate
    // counts at edges e+1 .. e+G, where e is the edge that accepted start.
    function automatic int unsigned model_edges(input int unsigned e);
        int unsigned n = 0;
        for (int k = int'(e) - 2; k <= int'(e) + int'(G) - 3; k++) begin
            if (k >= 1 && hist[k] && !hist[k-1]) n++;
        end
        return n;
    endfunction

    // Start a gate and wait (bounded) for valid. Optionally pulse start mid-gate or raise
    // sig_in after a given number of gate ticks.
    task automatic measure(input int start_at, input int rise_at, output int unsigned e);
        int lat;
        start = 1'b1;
        tick();
        e = hist.size() - 1;
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 300) begin
            tick();
            lat++;
            start = (lat == start_at);
            if (lat == rise_at) sig_in = 1'b1;
            if (lat == 50) check("busy_mid_gate", {63'd0, busy}, 64'd1);
        end
        start = 1'b0;
        check("latency", lat, G);
        check("valid_both", {63'd0, valid4}, 64'd1);
    endtask

    task automatic check_result(input string name, input int unsigned n);
        check({name, "_count"}, count, n);
        check({name, "_ovf"}, {63'd0, overflow}, 64'd0);
        check({name, "_count4"}, count4, (n > 15) ? 15 : n);
        check({name, "_ovf4"}, {63'd0, ovf4}, (n > 15) ? 1 : 0);
    endtask

    task automatic handshake(input int stall, input int unsigned n);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", {63'd0, valid}, 64'd1);
            check("stall_count", count, n);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("hs_valid_drop", {63'd0, valid}, 64'd0);
        check("hs_busy", {63'd0, busy}, 64'd0);
    endtask

    typedef struct {
        int          per;   // 0 means sig_in held high
        int unsigned exp32;
    } vec_t;

    initial begin
        vec_t        tbl[6];
        int unsigned e;
        int unsigned n;
        int          cnt;

        tbl[0] = '{10, 10};
        tbl[1] = '{4, 25};
        tbl[2] = '{20, 5};
        tbl[3] = '{50, 2};
        tbl[4] = '{100, 1};
        tbl[5] = '{0, 0};

        for (int i = 0; i < 4; i++) tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_count", count, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);

`ifdef FREQ_METER_CONTINUOUS_EN
        mode = 1; period = 20; phase = 0; ready = 1'b1;
        nreset = 1'b1;
        tick();
        check("cont_first_gate", {63'd0, busy}, 64'd1);
        for (int r = 0; r < 3; r++) begin
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (!valid && cnt < 300);
            check("cont_interval", cnt, (r == 0) ? G : G + 1);
            check("cont_count", count, 64'd5);
            check("cont_count4", count4, 64'd5);
            check("cont_ovf", {63'd0, overflow}, 64'd0);
        end
`else
        nreset = 1'b1;
        tick();
        tick();
        check("idle_no_start", {63'd0, busy}, 64'd0);

        // Table: periodic sig_in with periods dividing the gate length.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].per == 0) begin
                mode = 0;
                sig_in = 1'b1;
            end else begin
                mode = 1;
                period = tbl[i].per;
                phase = 0;
            end
            for (int j = 0; j < 10; j++) tick();
            measure(-1, -1, e);
            check_result("table", tbl[i].exp32);
            check("table_model", model_edges(e), tbl[i].exp32);
            handshake((i == 0) ? 20 : 0, tbl[i].exp32);
        end

        // Randomized sig_in density against the reference model.
        mode = 2;
        for (int r = 0; r < 8; r++) begin
            dens = $urandom_range(2, 60);
            for (int j = 0; j < 5; j++) tick();
            measure(-1, -1, e);
            n = model_edges(e);
            check_result("random", n);
            handshake(0, n);
        end

        // start during GATE is ignored; start with ready in DONE only completes handshake.
        mode = 1; period = 10; phase = 0;
        for (int j = 0; j < 10; j++) tick();
        measure(30, -1, e);
        check_result("start_in_gate", 10);
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b0;
        check("done_start_valid", {63'd0, valid}, 64'd0);
        check("done_start_busy", {63'd0, busy}, 64'd0);
        tick();
        check("done_start_no_gate", {63'd0, busy}, 64'd0);

        // Single rise whose pulse lands on the last GATE cycle, then on the first DONE cycle.
        mode = 0; sig_in = 1'b0;
        for (int j = 0; j < 10; j++) tick();
        measure(-1, G - 4, e);
        check_result("last_gate_edge", 1);
        check("last_gate_model", model_edges(e), 64'd1);
        handshake(0, 1);
        sig_in = 1'b0;
        for (int j = 0; j < 10; j++) tick();
        measure(-1, G - 3, e);
        check_result("first_done_edge", 0);
        handshake(0, 0);
        sig_in = 1'b0;

        // Reset 50 cycles into a gate discards the measurement.
        mode = 1; period = 4; phase = 0;
        for (int j = 0; j < 10; j++) tick();
        measure(-1, -1, e);
        handshake(0, 25);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 50; j++) tick();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_valid", {63'd0, valid}, 64'd0);
        check("midrst_count", count, 64'd0);
        check("midrst_ovf", {63'd0, overflow}, 64'd0);
        check("midrst_count4", count4, 64'd0);
        cnt = 0;
        for (int j = 0; j < 150; j++) begin
            tick();
            if (valid || busy) cnt++;
        end
        check("midrst_no_valid", cnt, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 27000000, meaning gate length in clk cycles (1 s at 27 MHz); legal range 2 to 2^32-1.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, meaning width of the edge counter and the count output.
REQ-003 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port nreset  input  1  synchronous reset, active-low.
REQ-005 SHALL have port sig_in  input  1  measured signal, asynchronous to clk.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a measurement.
REQ-007 SHALL have port busy  output  1  high while a measurement is in progress.
REQ-008 SHALL have port valid  output  1  result available.
REQ-009 SHALL have port ready  input  1  consumer accepts the result.
REQ-010 SHALL have port count  output  COUNT_WIDTH  number of rising edges seen in the last gate.
REQ-011 SHALL have port overflow  output  1  edge counter saturated during the last gate.

Function
REQ-012 SHALL pass sig_in through a 2-flop synchronizer, then a rising-edge detector: one-cycle pulse, 3 clk latency from sig_in rise.
REQ-013 SHALL implement FSM IDLE, GATE, DONE.
REQ-014 IDLE: start=1 SHALL clear the edge counter and overflow, load the gate counter with GATE_CYCLES-1, and go to GATE on the next cycle.
REQ-015 GATE: SHALL last exactly GATE_CYCLES clk cycles; each edge pulse in that window SHALL increment the edge counter by 1.
REQ-016 Edge counter SHALL saturate at all-ones; a pulse at all-ones SHALL set the sticky overflow flag.
REQ-017 When the gate counter reaches 0, the FSM SHALL go to DONE, latch the edge counter into count and overflow into overflow, and assert valid.
REQ-018 DONE: valid SHALL stay high, and count and overflow SHALL stay stable, until a cycle with valid=1 and ready=1; on that cycle the FSM SHALL go to IDLE and valid SHALL drop on the next cycle.
REQ-019 busy SHALL equal (state==GATE).
REQ-020 start SHALL be ignored in GATE and DONE.
REQ-021 An edge pulse on the last GATE cycle SHALL be counted; a pulse on the first DONE cycle SHALL not be counted.
REQ-022 start and ready both high in DONE SHALL only complete the handshake; no new measurement SHALL begin that cycle.

Reset
REQ-023 nreset=0 at a clk edge SHALL force IDLE, busy=0, valid=0, count=0, overflow=0, and clear the synchronizer flops and both counters.
REQ-024 Reset mid-GATE or mid-DONE SHALL discard the measurement, with no valid pulse afterwards.

Configuration
REQ-025 With FREQ_METER_CONTINUOUS_EN defined, DONE SHALL go directly to a fresh GATE after the handshake, with no start needed and no idle cycle between gates.
REQ-026 With FREQ_METER_CONTINUOUS_EN defined, the first gate SHALL begin 1 cycle after reset release.
REQ-027 With FREQ_METER_CONTINUOUS_EN defined, start SHALL be ignored.
REQ-028 Without FREQ_METER_CONTINUOUS_EN, behaviour SHALL be as in REQ-014..REQ-022.

Structure
REQ-029 Package freq_meter_pkg SHALL hold the FSM state enum (IDLE, GATE, DONE) and the synchronizer depth constant (2).
REQ-030 Synchronizer and edge detector SHALL be sub-module sync_edge_detect (ports clk, nreset, d, rise).
REQ-031 Gate counter width SHALL be $clog2(GATE_CYCLES).

Verification
REQ-032 GATE_CYCLES=100: sig_in period 10 clk, start -> valid after 101 cycles, count=10, overflow=0.
REQ-033 COUNT_WIDTH=4, GATE_CYCLES=100, sig_in period 4 clk -> count=15, overflow=1.
REQ-034 ready held low for 20 cycles after valid -> valid and count stable throughout; ready=1 -> valid=0 next cycle, FSM in IDLE.
REQ-035 nreset pulsed at cycle 50 of GATE -> all outputs 0; no valid without a new start.
REQ-036 sig_in constant 1 -> count=0; single sig_in rise placed so its pulse lands on the last GATE cycle -> count=1.
REQ-037 FREQ_METER_CONTINUOUS_EN defined, ready tied high, sig_in period 20 clk, GATE_CYCLES=100 -> valid every 101 cycles, each count=5.
